// File: rtl/ln_binarize_seq.sv
// ln_binarize_seq: streaming binarised layer-norm stage.
// Each beat carries CH input bits for time step t. Every channel computes
// y = x*alpha[blk][t] + beta[blk][t] and emits (y > 0). The coefficients
// live in a runtime-writable register file (NBLK blocks of T entries), and
// each frame selects one block.
// Optional build macro LN_BIPOLAR_EN: when defined, an input bit maps to
// x in {-1,+1} instead of {0,1}.
module ln_binarize_seq #(
    parameter int CH   = 16,
    parameter int T    = 30,
    parameter int CW   = 8,
    parameter int NBLK = 8,
    localparam int BW  = (NBLK > 1) ? $clog2(NBLK) : 1,
    localparam int TW  = (T > 1) ? $clog2(T) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 coef_we,
    input  logic [BW-1:0]        coef_blk,
    input  logic [TW-1:0]        coef_t,
    input  logic signed [CW-1:0] coef_alpha,
    input  logic signed [CW-1:0] coef_beta,
    input  logic                 start,
    input  logic [BW-1:0]        blk_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH-1:0]        in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH-1:0]        out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int DEPTH = NBLK * T;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(T - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t               state;
    logic [TW-1:0]        t;
    logic [BW-1:0]        blk;

    // Each entry packs {alpha, beta}.
    logic [2*CW-1:0]      coef_mem [DEPTH];

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        rd_addr;
    logic signed [CW-1:0] rd_alpha;
    logic signed [CW-1:0] rd_beta;
    logic signed [CW:0]   alpha_ext;
    logic signed [CW:0]   beta_ext;
    logic signed [CW:0]   sum_one;
    logic signed [CW:0]   sum_zero;
    logic                 bit_one;
    logic                 bit_zero;
    logic [CH-1:0]        out_next;
    logic                 accept;
    logic                 xfer;

    // Writes are only allowed between frames, and out-of-range indices are
    // dropped so they cannot alias into a neighbouring block.
    assign wr_en   = coef_we && (state == IDLE)
                     && (32'(coef_blk) < NBLK) && (32'(coef_t) < T);
    assign wr_addr = AW'(32'(coef_blk) * T + 32'(coef_t));
    assign rd_addr = AW'(32'(blk) * T + 32'(t));

    // Coefficient register file write port.
    // NOTE: the coefficient array has no reset; its contents survive rst_n by design,
    // and leaving it out of the reset tree keeps it a plain storage array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            coef_mem[wr_addr] <= {coef_alpha, coef_beta};
        end
    end

    assign rd_alpha = coef_mem[rd_addr][2*CW-1:CW];
    assign rd_beta  = coef_mem[rd_addr][CW-1:0];

    // One extra bit of headroom so that extreme coefficients never wrap.
    always_comb begin
        alpha_ext = {rd_alpha[CW-1], rd_alpha};
        beta_ext  = {rd_beta[CW-1], rd_beta};
        sum_one   = beta_ext + alpha_ext;
`ifdef LN_BIPOLAR_EN
        sum_zero  = beta_ext - alpha_ext;
`else
        sum_zero  = beta_ext;
`endif
        // Strictly positive: the sign bit is clear and the value is non-zero.
        bit_one   = !sum_one[CW] && (sum_one != '0);
        bit_zero  = !sum_zero[CW] && (sum_zero != '0);
        out_next  = (in_data & {CH{bit_one}}) | (~in_data & {CH{bit_zero}});
    end

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    // Frame sequencer with registered output stage.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values and the block order is irrelevant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            t         <= '0;
            blk       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse belongs to the old frame.
                    if (start && !done) begin
                        blk   <= (32'(blk_sel) < NBLK) ? blk_sel : '0;
                        t     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        out_data  <= out_next;
                        out_valid <= 1'b1;
                        out_last  <= (t == T_LAST);
                        if (t == T_LAST) begin
                            t     <= '0;
                            state <= FLUSH;
                        end else begin
                            t <= t + 1'b1;
                        end
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            out_last <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ln_binarize_seq.sv
// tb_ln_binarize_seq: directed bench for ln_binarize_seq (CH=16, T=30,
// CW=8, NBLK=8). Expected values are hand-derived per coefficient block.
module tb_ln_binarize_seq;

    localparam int T = 30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              coef_we;
    logic [2:0]        coef_blk;
    logic [4:0]        coef_t;
    logic signed [7:0] coef_alpha;
    logic signed [7:0] coef_beta;
    logic              start;
    logic [2:0]        blk_sel;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_err = 0;

    ln_binarize_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_we    (coef_we),
        .coef_blk   (coef_blk),
        .coef_t     (coef_t),
        .coef_alpha (coef_alpha),
        .coef_beta  (coef_beta),
        .start      (start),
        .blk_sel    (blk_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-beat XOR mask; with a pass-through block the output equals the input.
    function automatic logic [15:0] pat(input int k, input bit vary);
        return vary ? 16'(k * 37 + 1) : 16'h0000;
    endfunction

    task automatic write_coef(input int blk, input int t, input int a, input int b);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_blk   = 3'(blk);
        coef_t     = 5'(t);
        coef_alpha = 8'(a);
        coef_beta  = 8'(b);
        @(negedge clk);
        coef_we    = 1'b0;
    endtask

    task automatic write_blk(input int blk, input int a, input int b);
        for (int k = 0; k < T; k++) write_coef(blk, k, a, b);
    endtask

    // Runs one frame. stall_at >= 0 holds out_ready low for 5 cycles from that
    // loop cycle; wr_run drives coef_we while the frame runs; abort_at >= 0
    // returns early once that many beats have been offered for acceptance.
    task automatic run_frame(input string name, input int blk, input logic [15:0] din,
                             input logic [15:0] exp, input bit vary, input int stall_at,
                             input bit wr_run, input int abort_at);
        int  sent = 0, recv = 0, cyc = 0, done_cnt = 0, last_cnt = 0, last_idx = -1;
        bit  done_seen = 0;
        @(negedge clk);
        start   = 1'b1;
        blk_sel = 3'(blk);
        @(negedge clk);
        start = 1'b0;
        #1;
        check({name, "_busy_run"}, 32'(busy), 32'd1);
        while (!done_seen && cyc < 200) begin
            out_ready  = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
            in_valid   = (sent < T);
            in_data    = din ^ pat(sent, vary);
            coef_we    = wr_run && (sent < T);
            coef_blk   = 3'(blk);
            coef_t     = 5'(cyc % T);
            coef_alpha = -8'sd128;
            coef_beta  = -8'sd128;
            #1;
            if (done) begin
                done_cnt++;
                done_seen = 1;
                start     = 1'b1;
            end
            if (out_valid && !out_ready) begin
                check({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
                check({name, "_stall_hold"}, 32'(out_data), 32'(exp ^ pat(recv, vary)));
            end
            if (out_valid && out_ready) begin
                check({name, "_beat_data"}, 32'(out_data), 32'(exp ^ pat(recv, vary)));
                if (out_last) begin
                    last_cnt++;
                    last_idx = recv;
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            if (abort_at >= 0 && sent == abort_at) begin
                coef_we = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        coef_we  = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        check({name, "_done_seen"}, 32'(done_seen), 32'd1);
        #1;
        check({name, "_done_once"}, 32'(done_cnt + int'(done)), 32'd1);
        check({name, "_restart_ignored"}, 32'(busy), 32'd0);
        check({name, "_sent"}, 32'(sent), 32'(T));
        check({name, "_recv"}, 32'(recv), 32'(T));
        check({name, "_last_cnt"}, 32'(last_cnt), 32'd1);
        check({name, "_last_idx"}, 32'(last_idx), 32'(T - 1));
    endtask

    initial begin
        rst_n      = 1'b0;
        coef_we    = 1'b0;
        coef_blk   = '0;
        coef_t     = '0;
        coef_alpha = '0;
        coef_beta  = '0;
        start      = 1'b0;
        blk_sel    = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through block: alpha=5, beta=-3 gives 2 for a one and -3 (or -8) for a zero.
        write_blk(2, 5, -3);
        // t=30 is out of range; unguarded it would alias block 2, t=0.
        write_coef(1, 30, -128, -128);
        run_frame("a5a5", 2, 16'hA5A5, 16'hA5A5, 0, -1, 0, -1);

        // Sum of exactly zero for ones must give 0.
        write_blk(3, 3, -3);
        run_frame("zero_sum", 3, 16'hFFFF, 16'h0000, 0, -1, 0, -1);

        // alpha=4, beta=1: ones give 5, zeros give 1 (or -3 in the bipolar build).
        write_blk(4, 4, 1);
`ifdef LN_BIPOLAR_EN
        run_frame("pos_blk", 4, 16'h1234, 16'h1234, 0, -1, 0, -1);
`else
        run_frame("pos_blk", 4, 16'h1234, 16'hFFFF, 0, -1, 0, -1);
`endif

        // Backpressure mid-frame with varying data.
        run_frame("stall", 2, 16'h3C0F, 16'h3C0F, 1, 8, 0, -1);

        // Writes during RUN must be dropped; the next frame reproduces the previous one.
        run_frame("wr_run", 2, 16'h5A5A, 16'h5A5A, 1, -1, 1, -1);
        run_frame("after_wr", 2, 16'h5A5A, 16'h5A5A, 1, -1, 0, -1);

        // Extremes: 127+127=254 -> 1, -128-128=-256 -> 0, with no wrap.
        write_blk(5, 127, 127);
        run_frame("max", 5, 16'hFFFF, 16'hFFFF, 0, -1, 0, -1);
        write_blk(6, -128, -128);
        run_frame("min", 6, 16'hFFFF, 16'h0000, 0, -1, 0, -1);

        // Reset mid-frame at beat 10, then a clean full frame.
        run_frame("abort", 2, 16'hA5A5, 16'hA5A5, 0, -1, 0, 10);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_out_last", 32'(out_last), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        run_frame("post_rst", 2, 16'hC3C3, 16'hC3C3, 1, -1, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ln_binarize_seq.md
Name: ln_binarize_seq

Overview:
- Parametrised, streaming successor of the binarised layer-norm stage in the encoder pipeline.
- Per time step t, applies a signed affine y = x*alpha[blk][t] + beta[blk][t] to each of CH input bits, then thresholds strictly at >0 to give one output bit per channel.
- Coefficients are held in an internal register file that can be written at runtime, and are selectable per block.
- Valid/ready handshake on both sides, frame sequencing via FSM, one-cycle `done` pulse at end of frame.

Parameters:
- CH, 16, channels per beat (width of in_data/out_data)
- T, 30, time steps per frame
- CW, 8, signed coefficient width for alpha and beta
- NBLK, 8, number of coefficient blocks (encoder layers)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- coef_we  in  1  coefficient write strobe
- coef_blk  in  $clog2(NBLK)  write block index
- coef_t  in  $clog2(T)  write time-step index
- coef_alpha  in  CW  signed alpha write data
- coef_beta  in  CW  signed beta write data
- start  in  1  begin frame; samples blk_sel
- blk_sel  in  $clog2(NBLK)  block used for the frame
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  CH  input bit vector
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_data  out  CH  thresholded bits
- out_last  out  1  marks beat t == T-1
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, busy=0, done=0, in_ready=0, FSM=IDLE, t=0, blk=0.
- Coefficient RAM holds NBLK*T entries of {alpha,beta}. Reset does not clear it.
- Coefficient writes take effect on the clock edge when coef_we=1 and FSM==IDLE.
- A write is ignored if FSM!=IDLE, coef_blk>=NBLK, or coef_t>=T.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: start=1 latches blk_sel into blk, sets t=0, moves to RUN. If blk_sel>=NBLK, the frame is still started but uses blk=0.
  - RUN: in_ready = ~out_valid | out_ready. Each accepted beat computes and registers out_data, sets out_valid=1, out_last=(t==T-1), and increments t. Accepting beat t==T-1 moves the FSM to FLUSH.
  - FLUSH: in_ready=0. When the last beat is transferred (out_valid & out_ready & out_last), done=1 for exactly that cycle and the FSM returns to IDLE.
- start outside IDLE is ignored. in_valid outside RUN is ignored (in_ready=0).
- Arithmetic, per channel i:
  - x = in_data[i] (0 or 1)
  - sum = x ? (alpha+beta) : beta, computed in CW+1 signed bits with no overflow
  - out_data[i] = (sum > 0). sum==0 gives 0.
- Latency: 1 cycle from input acceptance to out_valid. Throughput is 1 beat/cycle when out_ready=1.
- Backpressure: while out_valid & ~out_ready, out_data and out_last hold, and in_ready=0.
- out_valid drops the cycle after a transfer unless a new beat was accepted in the same cycle.
- A new start in the same cycle as done is ignored; start is accepted in IDLE only.
- T=1: the first accepted beat carries out_last=1.
- busy=1 in RUN and FLUSH.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is discarded and no done is issued.

Optional Feature:
- Macro LN_BIPOLAR_EN.
- Defined: the input bit maps to x ∈ {-1,+1}, so sum = in_data[i] ? (beta+alpha) : (beta-alpha), computed in CW+1 bits.
- Undefined: x ∈ {0,1} as above.
- Ports, latency and FSM are identical in both builds.

Test Plan:
- Write blk 2, t=0..29 with alpha=5, beta=-3. Frame on blk 2 with in_data=16'hA5A5 each beat -> out_data=16'hA5A5 for 30 beats, out_last on beat 29, done pulses once after the last transfer.
- alpha=3, beta=-3 (sum==0 for ones) -> out_data=16'h0000 for in_data=16'hFFFF (strict >0). With LN_BIPOLAR_EN, alpha=3, beta=-3 -> also 16'h0000, since 0 and -6 are not >0. With alpha=4, beta=1 -> out_data=16'hFFFF for any input.
- Hold out_ready=0 for 5 cycles mid-frame -> out_data stable, in_ready=0, no beat lost or duplicated, t counts exactly 30.
- coef_we asserted during RUN with alpha=-128 -> RAM unchanged; a following frame reproduces the previous outputs.
- Assert rst_n=0 at beat 10 -> all outputs 0, FSM IDLE, no done. A new start runs a full 30-beat frame from t=0.
- Extremes alpha=127, beta=127 and alpha=-128, beta=-128 -> sum=254 gives 1, and sum=-256 gives 0, for every channel (no wrap).
